// File: rtl/keccak_pkg.sv
// keccak_pkg: constants, serializer FSM state type and lane-extraction
// helper shared by the Keccak output-side blocks.
//   KECCAK_STATE_W : width of the full Keccak-f[1600] state
//   KECCAK_LANE_W  : width of one lane
//   KECCAK_LANES   : number of lanes in the state
//   ser_state_t    : IDLE (waiting for a state) / SEND (emitting lanes)
//   lane(s, i)     : returns lane i of state s, lane i = s[64*i+63 : 64*i]
package keccak_pkg;

    localparam int KECCAK_STATE_W = 1600;
    localparam int KECCAK_LANE_W  = 64;
    localparam int KECCAK_LANES   = 25;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic logic [KECCAK_LANE_W-1:0] lane(
        input logic [KECCAK_STATE_W-1:0] s,
        input int                        i
    );
        return s[i*KECCAK_LANE_W +: KECCAK_LANE_W];
    endfunction

endpackage

// File: rtl/keccak_digest_serializer.sv
// keccak_digest_serializer: captures a finished 1600-bit Keccak state and
// streams its leading DIGEST_LANES lanes out as 64-bit words.
//
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   state_in    : permutation state, lane i = state_in[64*i+63 : 64*i]
//   state_valid : state_in holds a finished state
//   state_ready : state_in is captured this cycle if state_valid
//   dout        : current digest lane (registered)
//   dout_valid  : dout holds a valid lane (registered)
//   dout_ready  : consumer accepts dout this cycle
//   dout_last   : dout is lane DIGEST_LANES-1 (registered)
//   busy        : a digest is held or being emitted (registered)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds its data and valid until that edge; the
// ready side may change freely. state_valid is never sampled when
// state_ready is low, and no output depends combinationally on state_valid.
module keccak_digest_serializer
    import keccak_pkg::*;
#(
    parameter int DIGEST_LANES = 8,
    parameter int LANE_W       = KECCAK_LANE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [KECCAK_STATE_W-1:0] state_in,
    input  logic                      state_valid,
    output logic                      state_ready,
    output logic [LANE_W-1:0]         dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      dout_last,
    output logic                      busy
);

    localparam int IDX_W = (DIGEST_LANES > 1) ? $clog2(DIGEST_LANES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGEST_LANES - 1);

    ser_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_next;
    logic [LANE_W-1:0] buffer_q [DIGEST_LANES];
    logic [LANE_W-1:0] dout_q, dout_d;
    logic              last_q, last_d;
    logic              capture;

    // idx only advances while it is below IDX_LAST, so this never wraps.
    assign idx_next = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dout_d      = dout_q;
        last_d      = last_q;
        capture     = 1'b0;
        state_ready = 1'b0;
        case (state_q)
            IDLE: begin
                state_ready = 1'b1;
            end
            SEND: begin
                if (dout_ready) begin
                    if (!last_q) begin
                        idx_d  = idx_next;
                        dout_d = buffer_q[idx_next];
                        last_d = (idx_next == IDX_LAST);
                    end else begin
                        // Last lane leaves this cycle: the slot is free
                        // for a new state without an idle bubble.
                        state_ready = 1'b1;
                        state_d     = IDLE;
                        idx_d       = '0;
                        dout_d      = '0;
                        last_d      = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_ready && state_valid) begin
            capture = 1'b1;
            state_d = SEND;
            idx_d   = '0;
            dout_d  = lane(state_in, 0);
            last_d  = (DIGEST_LANES == 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dout_q  <= '0;
            last_q  <= 1'b0;
            for (int i = 0; i < DIGEST_LANES; i++) begin
                buffer_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            last_q  <= last_d;
            // Only the digest lanes are kept; lanes DIGEST_LANES..24 are
            // dropped at capture.
            if (capture) begin
                for (int i = 0; i < DIGEST_LANES; i++) begin
                    buffer_q[i] <= lane(state_in, i);
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_last  = last_q;
    assign dout_valid = (state_q == SEND);
    assign busy       = (state_q == SEND);

endmodule

// File: tb/tb_keccak_digest_serializer.sv
// Bench for keccak_digest_serializer: three instances (8, 4 and 1 digest
// lanes) exercised one at a time. Accepted states push their expected digest
// lanes into exp_q; a negedge monitor pops and compares on every transfer and
// predicts dout_valid/busy/state_ready from the number of lanes outstanding.
module tb_keccak_digest_serializer;

  logic          clk = 1'b0;
  logic          rst;
  logic [1599:0] state_in;
  logic          sv [3];
  logic          sr [3];
  logic          dv [3];
  logic          dl [3];
  logic          bz [3];
  logic          dr [3] = '{1'b1, 1'b1, 1'b1};
  logic [63:0]   dout [3];

  int vectors = 0;
  int miscompares = 0;
  logic [64:0] exp_q[$];
  int act = 0;
  int dr_mode = 0;
  int pc = 0;
  logic checking = 1'b0;

  keccak_digest_serializer #(.DIGEST_LANES(8)) u_dl8 (
    .clk(clk), .rst(rst), .state_in(state_in), .state_valid(sv[0]),
    .state_ready(sr[0]), .dout(dout[0]), .dout_valid(dv[0]),
    .dout_ready(dr[0]), .dout_last(dl[0]), .busy(bz[0]));

  keccak_digest_serializer #(.DIGEST_LANES(4)) u_dl4 (
    .clk(clk), .rst(rst), .state_in(state_in), .state_valid(sv[1]),
    .state_ready(sr[1]), .dout(dout[1]), .dout_valid(dv[1]),
    .dout_ready(dr[1]), .dout_last(dl[1]), .busy(bz[1]));

  keccak_digest_serializer #(.DIGEST_LANES(1)) u_dl1 (
    .clk(clk), .rst(rst), .state_in(state_in), .state_valid(sv[2]),
    .state_ready(sr[2]), .dout(dout[2]), .dout_valid(dv[2]),
    .dout_ready(dr[2]), .dout_last(dl[2]), .busy(bz[2]));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic int dl_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s (inst %0d): got %h expected %h at %0t", name, act, got, want, $time);
    end
  endtask

  // ---------------- consumer ready driver ----------------
  always @(posedge clk) begin
    logic v;
    #1;
    pc++;
    case (dr_mode)
      0: v = 1'b1;
      1: v = (pc % 3 == 0);
      default: v = 1'($urandom_range(0, 1));
    endcase
    for (int k = 0; k < 3; k++) dr[k] = v;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst && checking) begin
      int  n;
      logic exp_ready;
      n = exp_q.size();
      exp_ready = (n == 0) || (n == 1 && dr[act]);
      for (int k = 0; k < 3; k++)
        if (k != act) chk("idle_inst_valid", 64'(dv[k]), 64'd0);
      chk("dout_valid", 64'(dv[act]), 64'(n > 0));
      chk("busy", 64'(bz[act]), 64'(n > 0));
      chk("state_ready", 64'(sr[act]), 64'(exp_ready));
      if (dv[act] && n > 0) begin
        chk("dout", dout[act], exp_q[0][63:0]);
        chk("dout_last", 64'(dl[act]), 64'(exp_q[0][64]));
        if (dr[act]) void'(exp_q.pop_front());
      end
      if (sv[act] && exp_ready) begin
        for (int i = 0; i < dl_of(act); i++)
          exp_q.push_back({(i == dl_of(act) - 1), state_in[i*64 +: 64]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [1599:0] pat_state();
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) s[i*64 +: 64] = 64'h0101_0101_0101_0101 * 64'(i + 1);
    return s;
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) s[i*64 +: 64] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic send_state(input logic [1599:0] s);
    int n;
    state_in = s;
    sv[act] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (sr[act]) break;
      n++;
      if (n > 200) begin
        miscompares++;
        $display("FAIL send_timeout (inst %0d): state not accepted in 200 cycles", act);
        break;
      end
    end
    @(posedge clk);
    #2;
    sv[act] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 500) begin
        miscompares++;
        $display("FAIL drain_timeout (inst %0d): %0d lanes never emitted", act, exp_q.size());
        exp_q.delete();
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1599:0] a;
    rst = 1'b0;
    state_in = '0;
    for (int k = 0; k < 3; k++) sv[k] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      act = k;
      chk("reset_dout", dout[k], 64'd0);
      chk("reset_valid", 64'(dv[k]), 64'd0);
      chk("reset_last", 64'(dl[k]), 64'd0);
      chk("reset_busy", 64'(bz[k]), 64'd0);
      chk("reset_ready", 64'(sr[k]), 64'd1);
    end
    act = 0;
    checking = 1'b1;

    for (int k = 0; k < 3; k++) begin
      act = k;
      // straight digest with the consumer always ready
      dr_mode = 0;
      send_state(pat_state());
      wait_idle();
      // stalls 1,0,0 pattern
      dr_mode = 1;
      send_state(pat_state());
      wait_idle();
      // back-to-back: second state held valid while the first drains
      dr_mode = 0;
      a = pat_state();
      send_state(a);
      send_state(~a);
      wait_idle();
      // state_valid raised mid-digest, random stalls
      dr_mode = 2;
      send_state(rand_state());
      repeat (3) @(posedge clk);
      #2;
      send_state(rand_state());
      wait_idle();
      // random states with random gaps
      for (int j = 0; j < 6; j++) begin
        send_state(rand_state());
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #2;
      end
      wait_idle();
    end

    // asynchronous reset in the middle of a digest
    act = 0;
    dr_mode = 0;
    send_state(pat_state());
    begin
      int n;
      n = 0;
      while (exp_q.size() > 3 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    chk("midreset_valid", 64'(dv[0]), 64'd0);
    chk("midreset_dout", dout[0], 64'd0);
    chk("midreset_busy", 64'(bz[0]), 64'd0);
    chk("midreset_last", 64'(dl[0]), 64'd0);
    chk("midreset_ready", 64'(sr[0]), 64'd1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    send_state(~pat_state());
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keccak_digest_serializer.md
# keccak_digest_serializer

Output-side counterpart of the Keccak absorb/permute pipeline. It captures the 1600-bit state word presented by the permutation core and streams the leading digest lanes out as 64-bit words over a valid/ready handshake. It sits between the pipelined permutation core and the host or result interface: where the core's input side accepts packed message words, this block reads the finished state back out.

## Interface
Parameters:
- DIGEST_LANES, default 8: number of 64-bit lanes emitted per digest, legal range 1..25. 8 gives SHA3-512; 4 gives SHA3-256.
- LANE_W, default 64: lane width. Fixed by Keccak-f[1600]; not overridable in practice.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- state_in  input  1600  permutation state; lane i = state_in[64*i+63 : 64*i].
- state_valid  input  1  state_in holds a finished state.
- state_ready  output  1  block will capture state_in this cycle if state_valid.
- dout  output  64  current digest lane.
- dout_valid  output  1  dout holds a valid lane.
- dout_ready  input  1  consumer accepts dout this cycle.
- dout_last  output  1  current lane is lane DIGEST_LANES-1.
- busy  output  1  a digest is held or being emitted.

## Operation
- FSM with two states: IDLE and SEND.
- IDLE:
  - state_ready = 1.
  - On state_valid, capture lanes 0..DIGEST_LANES-1 into the capture buffer (DIGEST_LANES*64 bits), set idx = 0, and go to SEND.
  - Lanes DIGEST_LANES..24 are discarded.
- SEND:
  - dout_valid = 1, dout = buffer lane idx, dout_last = (idx == DIGEST_LANES-1).
  - On dout_valid & dout_ready & !dout_last: idx increments.
  - On dout_valid & dout_ready & dout_last:
    - If state_valid is high the same cycle, capture the new state, set idx = 0, and stay in SEND. This gives a zero-bubble back-to-back digest.
    - Otherwise return to IDLE.
  - state_ready = dout_valid & dout_ready & dout_last. It is 0 otherwise in SEND.
- Handshake rules:
  - While dout_valid = 1 and dout_ready = 0, dout, dout_last and idx are held stable.
  - dout_valid never drops without a transfer.
  - state_valid while state_ready = 0 is ignored. The producer must hold state_valid.
- idx width is clog2(DIGEST_LANES), minimum 1 bit. idx never exceeds DIGEST_LANES-1 and has no wrap-around path.
- DIGEST_LANES = 1: every accepted lane is also the last lane.
- busy = (state == SEND).
- Reset (rst = 0, asynchronous), in any state including mid-digest:
  - State returns to IDLE, idx = 0, buffer cleared to 0.
  - Outputs: dout = 0, dout_valid = 0, dout_last = 0, busy = 0.
  - state_ready = 1 once the reset has taken effect.
  - A partially emitted digest is lost and no further lanes of it are produced.

## Timing
- Capture to first lane: 1 cycle. state_valid & state_ready at edge N gives dout_valid = 1 after edge N.
- Throughput: 1 lane per cycle with dout_ready held high, so a full digest takes DIGEST_LANES cycles.
- Back-to-back digests have no idle cycle.
- dout, dout_valid, dout_last and busy are registered.
- state_ready is combinational from state and dout_ready.
- No combinational path from state_valid to any output.

## Structure
- Shared package keccak_pkg:
  - constants KECCAK_STATE_W = 1600, KECCAK_LANE_W = 64, KECCAK_LANES = 25.
  - the FSM state enum {IDLE, SEND}.
  - a lane-extraction function lane(state, i).
- Single module. No sub-module is needed; the capture buffer and the lane mux are inline.

## Test plan
- Reset release, then state_in lane i = 64'h0101_0101_0101_0101 * (i+1), pulse state_valid, dout_ready = 1 -> 8 consecutive lanes, lanes 0x0101..01 through 0x0808..08, dout_last on the 8th only, busy falls afterwards.
- Same stimulus with dout_ready toggling 1,0,0,1,... -> dout is held stable during every stall, lane order is preserved, no lane is duplicated or skipped.
- Second state (lane i = ~first state's lane i) presented with state_valid in the same cycle as the last lane's transfer -> state_ready = 1 in that cycle and the first lane of the new digest appears on the next cycle with no gap.
- state_valid asserted mid-digest (after lane 3) -> ignored until the last lane; the current digest completes unchanged.
- rst asserted after lane 5 -> dout_valid = 0, dout = 0 and busy = 0 immediately, state_ready = 1; a new state_valid afterwards restarts at lane 0.
- DIGEST_LANES = 4 and DIGEST_LANES = 1 builds -> exactly 4 lanes (respectively 1 lane) per digest, dout_last on the final lane, lanes 4..24 never emitted.
